// File: rtl/obuf_drain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : obuf_drain_ctrl                                             |
// | Desc   : Credit-gated output-buffer reader feeding a skid FIFO and   |
// |          a valid/ready stream with last marker.                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module obuf_drain_ctrl #(
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int CNT_W          = 16,
  parameter int SKID_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_W-1:0]          num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,
  output logic                      out_valid,
  output logic [MEM_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int                 c_PTR_W = $clog2(SKID_DEPTH);
  localparam logic [c_PTR_W+1:0] c_DEPTH = (c_PTR_W+2)'(SKID_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_ADDR_WIDTH-1:0] r_last_addr;
  logic [CNT_W-1:0]          r_issue_cnt;
  logic [CNT_W-1:0]          r_pop_cnt;
  logic                      r_inflight;
  logic [MEM_DATA_WIDTH-1:0] r_fifo [SKID_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_PTR_W:0]          r_count;
  logic                      w_issue;
  logic                      w_start;
  logic                      w_pop;
  logic                      w_credit;

  // Words in the FIFO plus the read still in flight must leave room; a
  // same-cycle pop is deliberately not counted.
  assign w_credit = ({1'b0, r_count} + {{(c_PTR_W+1){1'b0}}, r_inflight}) < c_DEPTH;

  assign out_valid     = (r_count != '0);
  assign out_data      = out_valid ? r_fifo[r_rd_ptr] : '0;
  assign out_last      = out_valid && (r_pop_cnt == CNT_W'(1));
  assign w_pop         = out_valid && out_ready;
  assign mem_read_req  = w_issue;
  assign mem_read_addr = w_issue ? r_addr : r_last_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start     = 1'b1;
          w_state_nxt = (num_words == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if ((r_issue_cnt != '0) && w_credit) begin
          w_issue = 1'b1;
          if (r_issue_cnt == CNT_W'(1)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && out_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr      <= base_addr;
        r_issue_cnt <= num_words;
        r_pop_cnt   <= num_words;
      end
      if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_last_addr <= r_addr;
        r_issue_cnt <= r_issue_cnt - 1'b1;
      end
      if (r_inflight) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_pop_cnt <= r_pop_cnt - 1'b1;
      end
      r_count <= r_count + {{c_PTR_W{1'b0}}, r_inflight} - {{c_PTR_W{1'b0}}, w_pop};
    end
  end

  // Read data is valid one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo[r_wr_ptr] <= mem_read_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/obuf_drain_ctrl.md
# obuf_drain_ctrl

Read-side sequencer for the output buffer's memory port. On a start command it walks a contiguous range of output-buffer memory addresses, issues one read per cycle under credit-based flow control, and re-times the returned words into an internal skid FIFO. It then presents them as a valid/ready stream with a last marker toward the DRAM write path. It sits between the tile-level controller (command side) and the output buffer's `mem_read_*` port.

## Interface

Parameters:
- `MEM_ADDR_WIDTH`, 11, width of the output buffer's memory-port address, with bank/buf_id bits in the LSBs (word-sequential).
- `MEM_DATA_WIDTH`, 64, width of one memory-port word.
- `CNT_W`, 16, width of the word-count command field.
- `SKID_DEPTH`, 4, skid FIFO entries; power of two, ≥3.

Ports:
- `clk`, input, 1, clock.
- `reset`, input, 1, synchronous, active-high.
- `start`, input, 1, command pulse; sampled only in IDLE.
- `base_addr`, input, MEM_ADDR_WIDTH, first memory-port address; sampled with `start`.
- `num_words`, input, CNT_W, number of words to drain; sampled with `start`.
- `busy`, output, 1, command in progress.
- `done`, output, 1, one-cycle completion pulse.
- `mem_read_req`, output, 1, read strobe to the output buffer.
- `mem_read_addr`, output, MEM_ADDR_WIDTH, read address.
- `mem_read_data`, input, MEM_DATA_WIDTH, read data, valid exactly 1 cycle after `mem_read_req`.
- `out_valid`, output, 1, stream word valid.
- `out_data`, output, MEM_DATA_WIDTH, stream word.
- `out_last`, output, 1, marks the final word of the command; qualified by `out_valid`.
- `out_ready`, input, 1, downstream accept.

## Operation

- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start`=1 latches `base_addr` into the address register and `num_words` into the issue and pop counters.
  - If `num_words`=0, go to DONE. Otherwise go to ISSUE.
- **ISSUE**
  - A read is issued (`mem_read_req`=1, `mem_read_addr`=address register) when issue_cnt>0 and fifo_count+inflight < SKID_DEPTH.
    - fifo_count is occupancy at the start of the cycle.
    - inflight is 1 if a read was issued in the previous cycle.
    - A pop in the same cycle is not credited.
  - Each issue increments the address modulo 2^MEM_ADDR_WIDTH (wraps silently) and decrements issue_cnt.
  - Go to DRAIN when the final read issues.
- **Capture**: in the cycle after any issue, `mem_read_data` is written into the skid FIFO. The FIFO never overflows by construction.
- **Stream out**
  - The FIFO head drives `out_data`; `out_valid` = FIFO not empty.
  - A pop occurs on `out_valid && out_ready` and decrements pop_cnt.
  - `out_last` = `out_valid` && pop_cnt==1.
- **DRAIN**: waits until the pop with `out_last` is accepted, then goes to DONE.
- **DONE**: asserts `done` for one cycle, then returns to IDLE.
- **`busy`**: 1 in ISSUE, DRAIN and DONE; 0 in IDLE.
- **Ignored stimulus**
  - `start` while not IDLE is ignored; the command inputs are not resampled.
  - `out_ready` without `out_valid` has no effect.
- **Reset** (at any time, including mid-command):
  - State returns to IDLE and the FIFO and counters are cleared.
  - Inflight data returning the next cycle is discarded.
  - No `done` is produced.

## Timing

- Reset values: `busy`=0, `done`=0, `mem_read_req`=0, `mem_read_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- With `start` accepted in cycle T:
  - First `mem_read_req` in T+1.
  - First FIFO write at the end of T+2.
  - First `out_valid` in T+3.
- With `out_ready` held at 1, sustained throughput is 1 word/cycle:
  - N words issue in T+1..T+N.
  - They pop in T+3..T+N+2.
  - `done` is in T+N+3.
- For `num_words`=0, `done` is in T+1 and no read or stream activity occurs.
- Under backpressure, at most SKID_DEPTH words are issued beyond the last pop. `mem_read_req` resumes the cycle after a pop frees credit.
- `out_data` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
- `mem_read_addr` holds its last issued value when `mem_read_req`=0.

## Test plan

- **Basic drain**
  - Stimulus: preload words 0xA0+i at addresses 0x10..0x17; start with `base_addr`=0x10, `num_words`=8; `out_ready`=1.
  - Required: reads at T+1..T+8 with addresses 0x10..0x17; `out_data` 0xA0..0xA7 in T+3..T+10; `out_last` only with 0xA7; `done` at T+11.
- **Backpressure**
  - Stimulus: `num_words`=10; `out_ready`=0 until T+20.
  - Required: exactly 4 reads issued, then `mem_read_req` stays 0; after `out_ready` rises, all 10 words arrive in order with no loss or duplication.
- **Random ready**
  - Stimulus: `num_words`=100; `out_ready` random at 50%.
  - Required: the output sequence matches memory order; FIFO occupancy never exceeds 4; `done` follows the `out_last` handshake by 1 cycle.
- **Zero length and start while busy**
  - Stimulus: `num_words`=0, then a second `start` pulsed during a 6-word command.
  - Required: the zero-length command gives `done` at T+1 with no reads; the second `start` produces no extra reads or `done`.
- **Address wrap**
  - Stimulus: `base_addr`=0x7FE (MEM_ADDR_WIDTH=11), `num_words`=4.
  - Required: read addresses 0x7FE, 0x7FF, 0x000, 0x001.
- **Mid-command reset**
  - Stimulus: assert `reset` 1 cycle after the 3rd word is popped, then release it and issue a new 2-word command.
  - Required: all outputs return to 0 the cycle after reset with no `done`; the new command behaves as in the basic drain.
